axil_mem_slave: RTL and testbench

AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

---
 rtl/axil_mem_slave.sv | 151 +++++++++++++++
 tb/tb_axil_mem_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave backed by a small byte-enabled memory.
// The write path holds one AW and one W buffer and commits once both are full
// and no write response is pending. The read path keeps one read in flight
// with a single cycle of latency. The two paths run independently.
module axil_mem_slave #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 128
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [1:0]            BRESP,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_W-1:0]     ARADDR,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int WORDS  = MEM_BYTES / STRB_W;
    localparam int WIDX   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

    // Memory is deliberately left without reset so contents survive ARESETN.
    logic [DATA_W-1:0] mem [WORDS];

    logic                aw_full;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic                w_full;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                rd_busy;
    logic [ADDR_W-1:0]   ar_addr_q;

    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;
    logic                commit;
    logic                aw_err;
    logic                ar_err;
    logic [WIDX-1:0]     w_idx;
    logic [WIDX-1:0]     r_idx;
    logic                aw_full_n;
    logic                w_full_n;
    logic                bvalid_n;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign b_hs   = BVALID && BREADY;
    assign commit = aw_full && w_full && !BVALID;
    assign aw_err = (aw_addr_q >= LIMIT);
    assign ar_err = (ar_addr_q >= LIMIT);
    assign w_idx  = aw_addr_q[OFF +: WIDX];
    assign r_idx  = ar_addr_q[OFF +: WIDX];

    // Next-state of the write buffers and response flag; drives the registered readies.
    always_comb begin
        aw_full_n = aw_full;
        w_full_n  = w_full;
        bvalid_n  = BVALID;
        if (commit) begin
            aw_full_n = 1'b0;
            w_full_n  = 1'b0;
            bvalid_n  = 1'b1;
        end else begin
            if (aw_hs) aw_full_n = 1'b1;
            if (w_hs)  w_full_n  = 1'b1;
            if (b_hs)  bvalid_n  = 1'b0;
        end
    end

    // Write channel buffers, response generation and ready registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
            w_full    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            BVALID    <= 1'b0;
            BRESP     <= 2'b00;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
        end else begin
            aw_full <= aw_full_n;
            w_full  <= w_full_n;
            BVALID  <= bvalid_n;
            if (aw_hs) aw_addr_q <= AWADDR;
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (commit) BRESP <= aw_err ? 2'b10 : 2'b00;
            // A pending response blocks new requests so only one pair is ever buffered.
            AWREADY <= !aw_full_n && !bvalid_n;
            WREADY  <= !w_full_n && !bvalid_n;
        end
    end

    // Byte-lane memory update at commit; out-of-range writes are dropped.
    always_ff @(posedge ACLK) begin
        if (commit && !aw_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb_q[i]) mem[w_idx][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
    end

    // Read path: capture address, sample memory next edge, hold until R handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ARREADY   <= 1'b0;
            rd_busy   <= 1'b0;
            ar_addr_q <= '0;
            RVALID    <= 1'b0;
            RDATA     <= '0;
            RRESP     <= 2'b00;
        end else begin
            if (ARVALID && ARREADY) begin
                ar_addr_q <= ARADDR;
                rd_busy   <= 1'b1;
                ARREADY   <= 1'b0;
            end else begin
                // Uses current flags, so ARREADY reopens one edge after the R handshake.
                ARREADY <= !rd_busy && !RVALID;
            end
            if (rd_busy) begin
                rd_busy <= 1'b0;
                RVALID  <= 1'b1;
                RDATA   <= ar_err ? '0 : mem[r_idx];
                RRESP   <= ar_err ? 2'b10 : 2'b00;
            end else if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_slave.sv
// Randomized bench for axil_mem_slave against a byte-array reference memory.
module tb_axil_mem_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 128;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [AW-1:0] AWADDR = '0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [DW-1:0] WDATA = '0;
    logic [3:0]    WSTRB = '0;
    logic          BVALID;
    logic          BREADY = 1'b0;
    logic [1:0]    BRESP;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [AW-1:0] ARADDR = '0;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] ref_mem [MB];

    axil_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(MB)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int b;
        if (a >= MB) return 32'h0;
        b = int'(a) & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int b;
        if (a >= MB) return;
        b = int'(a) & ~3;
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[b+i] = d[8*i +: 8];
    endfunction

    task automatic wait_clk;
        @(posedge ACLK);
        #1;
    endtask

    task automatic hs_aw(input logic [31:0] a);
        int n = 0;
        AWADDR = a;
        AWVALID = 1'b1;
        while (!AWREADY && n < 20) begin wait_clk; n++; end
        check("awready_timeout", 64'(n >= 20), 0);
        wait_clk;
        AWVALID = 1'b0;
    endtask

    task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        WDATA = d;
        WSTRB = s;
        WVALID = 1'b1;
        while (!WREADY && n < 20) begin wait_clk; n++; end
        check("wready_timeout", 64'(n >= 20), 0);
        wait_clk;
        WVALID = 1'b0;
    endtask

    // order 0: AW+W together, 1: AW first, 2: W three cycles before AW
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int order, input int bdelay);
        int n = 0;
        logic [1:0] exp_resp;
        exp_resp = (a >= MB) ? 2'b10 : 2'b00;
        case (order)
            0: begin
                AWADDR = a; WDATA = d; WSTRB = s;
                AWVALID = 1'b1; WVALID = 1'b1;
                while (!(AWREADY && WREADY) && n < 20) begin wait_clk; n++; end
                check("aw_w_ready_timeout", 64'(n >= 20), 0);
                wait_clk;
                AWVALID = 1'b0; WVALID = 1'b0;
            end
            1: begin
                hs_aw(a);
                check("awready_after_aw", 64'(AWREADY), 0);
                repeat ($urandom_range(0, 2)) begin
                    wait_clk;
                    check("bvalid_aw_only", 64'(BVALID), 0);
                end
                hs_w(d, s);
            end
            default: begin
                hs_w(d, s);
                for (int k = 0; k < 3; k++) begin
                    check("wready_w_only", 64'(WREADY), 0);
                    check("bvalid_w_only", 64'(BVALID), 0);
                    wait_clk;
                end
                hs_aw(a);
            end
        endcase
        check("bvalid_early", 64'(BVALID), 0);
        wait_clk;
        check("bvalid_latency", 64'(BVALID), 1);
        check("bresp", 64'(BRESP), 64'(exp_resp));
        for (int k = 0; k < bdelay; k++) begin
            wait_clk;
            check("bvalid_hold", 64'(BVALID), 1);
            check("bresp_hold", 64'(BRESP), 64'(exp_resp));
            check("awready_blocked", 64'(AWREADY), 0);
            check("wready_blocked", 64'(WREADY), 0);
        end
        BREADY = 1'b1;
        wait_clk;
        BREADY = 1'b0;
        check("bvalid_drop", 64'(BVALID), 0);
        check("awready_back", 64'(AWREADY), 1);
        check("wready_back", 64'(WREADY), 1);
        ref_write(a, d, s);
    endtask

    task automatic axi_read(input logic [31:0] a, input int rdelay);
        int n = 0;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        exp_d = ref_read(a);
        exp_r = (a >= MB) ? 2'b10 : 2'b00;
        ARADDR = a;
        ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin wait_clk; n++; end
        check("arready_timeout", 64'(n >= 20), 0);
        wait_clk;
        ARVALID = 1'b0;
        check("rvalid_early", 64'(RVALID), 0);
        check("arready_busy", 64'(ARREADY), 0);
        wait_clk;
        check("rvalid_latency", 64'(RVALID), 1);
        check("rdata", 64'(RDATA), 64'(exp_d));
        check("rresp", 64'(RRESP), 64'(exp_r));
        for (int k = 0; k < rdelay; k++) begin
            wait_clk;
            check("rvalid_hold", 64'(RVALID), 1);
            check("rdata_hold", 64'(RDATA), 64'(exp_d));
            check("arready_held_low", 64'(ARREADY), 0);
        end
        RREADY = 1'b1;
        wait_clk;
        RREADY = 1'b0;
        check("rvalid_drop", 64'(RVALID), 0);
        check("arready_hs_edge", 64'(ARREADY), 0);
        wait_clk;
        check("arready_reopen", 64'(ARREADY), 1);
    endtask

    // Write commit and read sample land on the same edge; read must see old data.
    task automatic collide(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        logic [31:0] old_d;
        old_d = ref_read(a);
        AWADDR = a; WDATA = d; WSTRB = 4'hF; ARADDR = a;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        while (!(AWREADY && WREADY && ARREADY) && n < 20) begin wait_clk; n++; end
        check("collide_ready_timeout", 64'(n >= 20), 0);
        wait_clk;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        wait_clk;
        check("collide_bvalid", 64'(BVALID), 1);
        check("collide_rvalid", 64'(RVALID), 1);
        check("collide_old_data", 64'(RDATA), 64'(old_d));
        BREADY = 1'b1; RREADY = 1'b1;
        wait_clk;
        BREADY = 1'b0; RREADY = 1'b0;
        wait_clk;
        ref_write(a, d, 4'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", 64'(AWREADY), 0);
        check("rst_wready", 64'(WREADY), 0);
        check("rst_arready", 64'(ARREADY), 0);
        check("rst_bvalid", 64'(BVALID), 0);
        check("rst_rvalid", 64'(RVALID), 0);
        check("rst_bresp", 64'(BRESP), 0);
        check("rst_rresp", 64'(RRESP), 0);
        check("rst_rdata", 64'(RDATA), 0);
        ARESETN = 1'b1;
        wait_clk;
        check("post_rst_awready", 64'(AWREADY), 1);
        check("post_rst_wready", 64'(WREADY), 1);
        check("post_rst_arready", 64'(ARREADY), 1);

        for (int w = 0; w < MB / 4; w++)
            axi_write(32'(w * 4), $urandom, 4'hF, 0, 0);

        axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read(32'h04, 0);

        axi_write(32'h08, 32'h11223344, 4'hF, 1, 1);
        axi_write(32'h08, 32'hAABBCCDD, 4'h5, 0, 0);
        axi_read(32'h08, 0);

        axi_write(32'h80, 32'h55667788, 4'hF, 0, 0);
        axi_read(32'h80, 0);
        axi_read(32'h00, 0);

        axi_write(32'h10, 32'hCAFEF00D, 4'hF, 2, 5);
        axi_read(32'h10, 4);

        collide(32'h14, 32'h0BADF00D);
        axi_read(32'h14, 0);

        hs_aw(32'h0C);
        ARESETN = 1'b0;
        #1;
        check("midrst_awready", 64'(AWREADY), 0);
        check("midrst_bvalid", 64'(BVALID), 0);
        wait_clk;
        wait_clk;
        ARESETN = 1'b1;
        wait_clk;
        check("midrst_awready_back", 64'(AWREADY), 1);
        for (int k = 0; k < 4; k++) begin
            wait_clk;
            check("midrst_no_bvalid", 64'(BVALID), 0);
        end
        axi_write(32'h0C, 32'h600DD00D, 4'hF, 0, 0);
        axi_read(32'h0C, 0);

        for (int t = 0; t < 80; t++) begin
            a = 32'($urandom_range(0, 159));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
            else
                axi_read(a, int'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
